// File: rtl/path_merge_2way.sv
// path_merge_2way: merges a forwarded packet stream (A) and a locally
// injected stream (B) into one output register. Each source has its own
// FIFO; when both hold data the grant alternates round-robin.
// Optional build macro PATH_MERGE_STATS_EN adds saturating per-source
// counters of writes dropped because the FIFO was full.
module path_merge_2way #(
   parameter int DATA_WIDTH = 23,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] din_a,
   input  logic                  wen_a,
   output logic                  full_a,
   input  logic [DATA_WIDTH-1:0] din_b,
   input  logic                  wen_b,
   output logic                  full_b,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  dout_valid,
   input  logic                  dout_ready,
   output logic                  dout_src
`ifdef PATH_MERGE_STATS_EN
   ,
   output logic [15:0]           drop_cnt_a,
   output logic [15:0]           drop_cnt_b
`endif
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   // Lane 0 is source A, lane 1 is source B.
   logic [DATA_WIDTH-1:0] w_din  [2];
   logic                  w_wen  [2];
   logic [DATA_WIDTH-1:0] w_head [2];
   logic                  w_full [2];
   logic                  w_empty[2];
   logic                  w_pop  [2];
`ifdef PATH_MERGE_STATS_EN
   logic [15:0]           w_drop [2];
`endif

   assign w_din[0] = din_a;
   assign w_din[1] = din_b;
   assign w_wen[0] = wen_a;
   assign w_wen[1] = wen_b;
   assign full_a   = w_full[0];
   assign full_b   = w_full[1];
`ifdef PATH_MERGE_STATS_EN
   assign drop_cnt_a = w_drop[0];
   assign drop_cnt_b = w_drop[1];
`endif

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_lane
         logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
         logic [AW-1:0]         r_wptr;
         logic [AW-1:0]         r_rptr;
         logic [AW:0]           r_count;
         logic                  w_push;

         // A write into a full FIFO is dropped even if that FIFO pops this cycle.
         assign w_push      = w_wen[gi] && !w_full[gi];
         assign w_full[gi]  = (r_count == (AW+1)'(FIFO_DEPTH));
         assign w_empty[gi] = (r_count == '0);
         assign w_head[gi]  = r_mem[r_rptr];

         // Storage array; contents are meaningless until counted in.
         always_ff @(posedge clk) begin
            if (w_push) begin
               r_mem[r_wptr] <= w_din[gi];
            end
         end

         // Pointers wrap naturally because the depth is a power of two.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_wptr  <= '0;
               r_rptr  <= '0;
               r_count <= '0;
            end else begin
               if (w_push) begin
                  r_wptr <= r_wptr + 1'b1;
               end
               if (w_pop[gi]) begin
                  r_rptr <= r_rptr + 1'b1;
               end
               case ({w_push, w_pop[gi]})
                  2'b10:   r_count <= r_count + 1'b1;
                  2'b01:   r_count <= r_count - 1'b1;
                  default: r_count <= r_count;
               endcase
            end
         end

`ifdef PATH_MERGE_STATS_EN
         logic [15:0] r_drop;
         assign w_drop[gi] = r_drop;

         // Count writes rejected by a full FIFO, sticking at all-ones.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_drop <= '0;
            end else if (w_wen[gi] && w_full[gi] && (r_drop != 16'hFFFF)) begin
               r_drop <= r_drop + 1'b1;
            end
         end
`endif
      end
   endgenerate

   // Arbitration: last grant reset to B so that A wins the first contention.
   logic r_last_grant;
   logic w_free;
   logic w_any;
   logic w_sel_b;

   assign w_free  = !dout_valid || dout_ready;
   assign w_any   = !(w_empty[0] && w_empty[1]);
   assign w_sel_b = w_empty[0] ? 1'b1 : (w_empty[1] ? 1'b0 : !r_last_grant);
   assign w_pop[0] = w_free && w_any && !w_sel_b;
   assign w_pop[1] = w_free && w_any &&  w_sel_b;

   // Output register: reload on every free edge, hold while stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dout         <= '0;
         dout_src     <= 1'b0;
         dout_valid   <= 1'b0;
         r_last_grant <= 1'b1;
      end else if (w_free) begin
         if (w_any) begin
            dout         <= w_sel_b ? w_head[1] : w_head[0];
            dout_src     <= w_sel_b;
            dout_valid   <= 1'b1;
            r_last_grant <= w_sel_b;
         end else begin
            dout_valid   <= 1'b0;
         end
      end
   end

endmodule

// File: doc/path_merge_2way.md
PATH_MERGE_2WAY -- requirements
Module: path_merge_2way

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 23: packet width on all data ports.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: entries per input FIFO; power of two, 2 or more.
REQ-003 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port din_a  input  DATA_WIDTH  packet from the neighbouring router's forward output.
REQ-006 SHALL have port wen_a  input  1  write strobe for din_a.
REQ-007 SHALL have port full_a  output  1  FIFO A holds FIFO_DEPTH entries.
REQ-008 SHALL have port din_b  input  DATA_WIDTH  locally injected packet, full dy field already present.
REQ-009 SHALL have port wen_b  input  1  write strobe for din_b.
REQ-010 SHALL have port full_b  output  1  FIFO B holds FIFO_DEPTH entries.
REQ-011 SHALL have port dout  output  DATA_WIDTH  merged packet toward the next hop.
REQ-012 SHALL have port dout_valid  output  1  dout holds a packet.
REQ-013 SHALL have port dout_ready  input  1  downstream accepts dout this cycle.
REQ-014 SHALL have port dout_src  output  1  source of dout: 0 = A, 1 = B.

Function
REQ-015 SHALL write din_x into FIFO x on a rising edge where wen_x=1 and full_x=0.
REQ-016 SHALL drop a write when full_x=1 in that cycle, even if the same FIFO is popped that cycle.
REQ-017 SHALL drive full_x combinationally from the registered count: count_x == FIFO_DEPTH.
REQ-018 SHALL pass packets unmodified, bit-exact; no dy arithmetic.
REQ-019 SHALL treat the output register as free when dout_valid=0, or when dout_valid=1 and dout_ready=1.
REQ-020 SHALL, when the output register is free, pop one FIFO and load dout, dout_src and dout_valid=1 on the same edge.
REQ-021 SHALL clear dout_valid on a free edge when both FIFOs are empty.
REQ-022 SHALL grant the only non-empty FIFO when exactly one is non-empty.
REQ-023 SHALL grant the FIFO not granted last when both are non-empty (round-robin); last_grant updates only on a grant.
REQ-024 SHALL hold dout, dout_src and dout_valid stable while dout_valid=1 and dout_ready=0.
REQ-025 SHALL give one-cycle latency: a packet written at edge n into an empty block with a free output appears with dout_valid=1 after edge n+1.
REQ-026 SHALL sustain one packet per cycle while dout_ready=1 and data is available.
REQ-027 SHALL wrap FIFO pointers modulo FIFO_DEPTH; simultaneous push and pop on a non-full FIFO leaves count unchanged.
REQ-028 SHALL preserve FIFO order within each source.

Reset
REQ-029 SHALL, on rst_n=0, immediately clear FIFO counts and pointers, dout_valid=0, dout=0, dout_src=0, and last_grant=B, so A wins first contention.
REQ-030 SHALL discard FIFO contents and any held output packet when reset is asserted mid-operation.
REQ-031 SHALL ignore wen_a and wen_b while rst_n=0.

Configuration
REQ-032 SHALL, with macro PATH_MERGE_STATS_EN defined, add outputs drop_cnt_a[15:0] and drop_cnt_b[15:0].
REQ-033 SHALL, with the macro, increment drop_cnt_x on each dropped write, saturate at 16'hFFFF, and reset both counters to 0.
REQ-034 SHALL, without the macro, omit these ports and counters; all other behaviour is identical.

Verification
REQ-035 SHALL test a single write: wen_a=1, din_a=23'h012345 at edge 0, dout_ready=1 -> after edge 1: dout=23'h012345, dout_valid=1, dout_src=0; after edge 2: dout_valid=0.
REQ-036 SHALL test contention: both FIFOs preloaded with 3 packets, dout_ready=1 -> sources A,B,A,B,A,B on consecutive cycles.
REQ-037 SHALL test backpressure: dout_ready=0 for 5 cycles with dout_valid=1 -> dout stable; FIFO A fills at 4 writes; full_a=1; 5th write dropped; with the macro, drop_cnt_a=1.
REQ-038 SHALL test order and wrap: 10 sequential writes 1..10 on B with dout_ready=1 -> dout 1..10 in order, no loss, full_b never asserts.
REQ-039 SHALL test mid-operation reset: rst_n=0 while both FIFOs hold data and dout_valid=1 -> dout_valid=0 and full_a=full_b=0 immediately; next contention grants A.
